// File: rtl/biu_slave_if.sv
// Request/ack channel between biu_slave (master side) and its local device (slave side).
// The master holds req and its fields stable until the device returns ack; read data is valid in the ack cycle.
interface biu_slave_if #(
    parameter int SIZE_BITS  = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  dev_req;
    logic                  dev_rnw;
    logic [SIZE_BITS-1:0]  dev_addr;
    logic [DATA_WIDTH-1:0] dev_wdata;
    logic                  dev_ack;
    logic [DATA_WIDTH-1:0] dev_rdata;

    modport master (
        output dev_req, dev_rnw, dev_addr, dev_wdata,
        input  dev_ack, dev_rdata
    );

    modport slave (
        input  dev_req, dev_rnw, dev_addr, dev_wdata,
        output dev_ack, dev_rdata
    );
endinterface

// File: rtl/biu_slave.sv
// Bus slave: decodes a window, runs one req/ack device access, returns read data on the bus for one cycle.
// Request at T -> dev_req at T+1; no queueing, hits while busy are dropped and flagged; BIU_SLAVE_TIMEOUT_EN adds an ack timeout.
module biu_slave #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 32'h0000_0000,
    parameter int                    SIZE_BITS      = 8,
    parameter int                    TIMEOUT_CYCLES = 16,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] bus_address,
    inout  wire  [DATA_WIDTH-1:0] bus_data,
    inout  wire  [1:0]            bus_control,
    biu_slave_if.master           dev,
    output logic                  busy,
    output logic                  overrun
`ifdef BIU_SLAVE_TIMEOUT_EN
    ,
    output logic                  timeout
`endif
);

    typedef enum logic [2:0] {
        IDLE    = 3'b001,
        ACCESS  = 3'b010,
        RESPOND = 3'b100
    } state_e;

    state_e                state_q, state_d;
    logic [SIZE_BITS-1:0]  addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rnw_q;
    logic                  overrun_q;
    logic                  hit;
    logic                  accept;
    logic                  ack;
    logic                  expire;
    logic                  drive;

    // BASE_ADDR is window-aligned, so an upper-bits match is the full range check
    assign hit    = bus_control[0] &&
                    (bus_address[ADDR_WIDTH-1:SIZE_BITS] == BASE_ADDR[ADDR_WIDTH-1:SIZE_BITS]);
    assign accept = (state_q == IDLE) && hit;
    assign ack    = (state_q == ACCESS) && dev.dev_ack;

`ifdef BIU_SLAVE_TIMEOUT_EN
    localparam int             CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic          timeout_q;

    // Ack takes priority over expiry in the same cycle
    assign expire  = (state_q == ACCESS) && !dev.dev_ack && (cnt_q == CNT_LAST);
    assign timeout = timeout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state_q != ACCESS) begin
                cnt_q <= '0;
            end else if (!dev.dev_ack) begin
                cnt_q <= cnt_q + 1'b1;
            end
            timeout_q <= expire;
        end
    end
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (hit) state_d = ACCESS;
            ACCESS:  if (dev.dev_ack || expire) state_d = rnw_q ? RESPOND : IDLE;
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dev.dev_req = (state_q == ACCESS);
        busy        = (state_q != IDLE);
        drive       = (state_q == RESPOND);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            rnw_q     <= 1'b0;
            rdata_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= bus_address[SIZE_BITS-1:0];
                wdata_q <= bus_data;
                rnw_q   <= bus_control[1];
            end
            if (ack && rnw_q) begin
                rdata_q <= dev.dev_rdata;
            end else if (expire && rnw_q) begin
                rdata_q <= ERR_DATA;
            end
            if (hit && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign dev.dev_rnw   = rnw_q;
    assign dev.dev_addr  = addr_q;
    assign dev.dev_wdata = wdata_q;
    assign overrun       = overrun_q;

    assign bus_data    = drive ? rdata_q : {DATA_WIDTH{1'bz}};
    assign bus_control = drive ? 2'b01   : 2'bzz;

endmodule

// File: tb/tb_biu_slave.sv
// Scoreboard bench for biu_slave: directed bus requests, a programmable-latency device model, decoupled monitors.
module tb_biu_slave;

    localparam logic [31:0] PARK = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] m_addr = PARK;
    logic [31:0] m_data = 32'h0;
    logic [1:0]  m_ctrl = 2'b00;
    logic        m_drv  = 1'b0;
    wire  [31:0] bus_data;
    wire  [1:0]  bus_control;
    logic        busy;
    logic        overrun;
`ifdef BIU_SLAVE_TIMEOUT_EN
    logic        timeout;
`endif

    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          ack_wait = 0;
    int          dev_cnt = 0;
    logic [31:0] rdata_v = 32'h0;

    typedef struct { logic [31:0] data; int cyc; } bus_exp_t;
    typedef struct { logic rnw; logic [7:0] addr; logic [31:0] wdata; int len; } dev_exp_t;
    bus_exp_t bus_q[$];
    dev_exp_t dev_q[$];

    biu_slave_if #(.SIZE_BITS(8), .DATA_WIDTH(32)) dev_if ();

    biu_slave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(32'h0000_1000), .SIZE_BITS(8),
        .TIMEOUT_CYCLES(4), .ERR_DATA(32'hDEAD_BEEF)
    ) dut (
        .clk(clk), .rst(rst), .bus_address(m_addr), .bus_data(bus_data),
        .bus_control(bus_control), .dev(dev_if), .busy(busy), .overrun(overrun)
`ifdef BIU_SLAVE_TIMEOUT_EN
        , .timeout(timeout)
`endif
    );

    assign bus_data    = m_drv ? m_data : 32'hzzzz_zzzz;
    assign bus_control = m_drv ? m_ctrl : 2'bzz;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Device model: acks after ack_wait idle cycles of dev_req; a negative ack_wait never acks
    assign dev_if.dev_ack   = dev_if.dev_req && (ack_wait >= 0) && (dev_cnt == ack_wait);
    assign dev_if.dev_rdata = rdata_v;
    always @(posedge clk) begin
        if (!dev_if.dev_req || dev_if.dev_ack) dev_cnt <= 0;
        else dev_cnt <= dev_cnt + 1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    // Bus response monitor
    always @(negedge clk) begin
        if (!m_drv && bus_control[0] === 1'b1) begin
            if (bus_q.size() == 0) begin
                chk("bus_unexpected_resp", {32'h0, bus_data}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                bus_exp_t e;
                e = bus_q.pop_front();
                chk("bus_rdata", {32'h0, bus_data}, {32'h0, e.data});
                chk("bus_resp_cycle", 64'(cyc), 64'(e.cyc));
                chk("bus_rnw_bit", {63'h0, bus_control[1]}, 64'h0);
            end
        end
    end

    // Device transaction monitor, with stability tracking over the request
    logic        unstable = 1'b0;
    logic        s_rnw;
    logic [7:0]  s_addr;
    logic [31:0] s_wdata;
    always @(negedge clk) begin
        if (dev_if.dev_req) begin
            if (dev_cnt == 0) begin
                s_rnw = dev_if.dev_rnw; s_addr = dev_if.dev_addr; s_wdata = dev_if.dev_wdata;
                unstable = 1'b0;
            end else if (s_rnw !== dev_if.dev_rnw || s_addr !== dev_if.dev_addr || s_wdata !== dev_if.dev_wdata) begin
                unstable = 1'b1;
            end
            if (dev_if.dev_ack) begin
                if (dev_q.size() == 0) begin
                    chk("dev_unexpected_txn", {56'h0, dev_if.dev_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    dev_exp_t d;
                    d = dev_q.pop_front();
                    chk("dev_rnw", {63'h0, dev_if.dev_rnw}, {63'h0, d.rnw});
                    chk("dev_addr", {56'h0, dev_if.dev_addr}, {56'h0, d.addr});
                    chk("dev_wdata", {32'h0, dev_if.dev_wdata}, {32'h0, d.wdata});
                    chk("dev_req_len", 64'(dev_cnt + 1), 64'(d.len));
                    chk("dev_stable", {63'h0, unstable}, 64'h0);
                end
            end
        end
    end

    // One-cycle bus request; expect_hit controls whether a device transaction/response is scheduled
    task automatic bus_req(input logic [31:0] addr, input logic [31:0] data, input logic rnw,
                           input bit expect_hit, output int t);
        dev_exp_t d;
        bus_exp_t b;
        @(posedge clk); #2;
        m_addr = addr; m_data = data; m_ctrl = {rnw, 1'b1}; m_drv = 1'b1;
        t = cyc;
        if (expect_hit && ack_wait >= 0) begin
            d.rnw = rnw; d.addr = addr[7:0]; d.wdata = data; d.len = ack_wait + 1;
            dev_q.push_back(d);
            if (rnw) begin
                b.data = rdata_v; b.cyc = t + 2 + ack_wait;
                bus_q.push_back(b);
            end
        end
        @(posedge clk); #2;
        m_drv = 1'b0; m_addr = PARK; m_ctrl = 2'b00;
    endtask

    task automatic at_cyc(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #2; rst = 1'b1;
        @(negedge clk);
        chk("rst_overrun_clear", {63'h0, overrun}, 64'h0);
        @(posedge clk); #2; rst = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (busy !== 1'b0 && n < 40);
        if (busy !== 1'b0) chk({nm, "_idle_bound"}, {63'h0, busy}, 64'h0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int t, t2;
        bus_exp_t b;
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_dev_req", {63'h0, dev_if.dev_req}, 64'h0);
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_overrun", {63'h0, overrun}, 64'h0);
        chk("rst_dev_rnw", {63'h0, dev_if.dev_rnw}, 64'h0);
        chk("rst_dev_addr", {56'h0, dev_if.dev_addr}, 64'h0);
        chk("rst_dev_wdata", {32'h0, dev_if.dev_wdata}, 64'h0);
        chk("rst_bus_undriven", {63'h0, bus_control[0] === 1'b1}, 64'h0);
        @(posedge clk); #2; rst = 1'b0;

        // Read with combinational ack
        ack_wait = 0; rdata_v = 32'hCAFE_F00D;
        bus_req(32'h0000_1004, 32'h0, 1'b1, 1'b1, t);
        at_cyc(t + 1);
        chk("rd_dev_req", {63'h0, dev_if.dev_req}, 64'h1);
        chk("rd_dev_addr", {56'h0, dev_if.dev_addr}, 64'h04);
        at_cyc(t + 3);
        chk("rd_bus_z_after", {63'h0, bus_control[0] === 1'b1}, 64'h0);
        chk("rd_busy_after", {63'h0, busy}, 64'h0);

        // Write at top of window, three wait cycles
        ack_wait = 3;
        bus_req(32'h0000_10FF, 32'h1234_5678, 1'b0, 1'b1, t);
        at_cyc(t + 4);
        chk("wr_busy_ack_cycle", {63'h0, busy}, 64'h1);
        at_cyc(t + 5);
        chk("wr_busy_fall", {63'h0, busy}, 64'h0);

        // Misses just above and just below the window
        bus_req(32'h0000_2000, 32'h0, 1'b1, 1'b0, t);
        at_cyc(t + 1);
        chk("miss_hi_req", {63'h0, dev_if.dev_req}, 64'h0);
        chk("miss_hi_busy", {63'h0, busy}, 64'h0);
        bus_req(32'h0000_0FFF, 32'h0, 1'b1, 1'b0, t);
        at_cyc(t + 1);
        chk("miss_lo_req", {63'h0, dev_if.dev_req}, 64'h0);
        chk("miss_lo_busy", {63'h0, busy}, 64'h0);
        chk("miss_overrun", {63'h0, overrun}, 64'h0);

        // Write acked at T+1, next request accepted at T+2
        ack_wait = 0; rdata_v = 32'h0BAD_CAFE;
        bus_req(32'h0000_1010, 32'hA5A5_5A5A, 1'b0, 1'b1, t);
        bus_req(32'h0000_1020, 32'h0, 1'b1, 1'b1, t2);
        wait_idle("b2b");
        chk("b2b_overrun", {63'h0, overrun}, 64'h0);

        // Overrun: second hit during a long read is dropped, flag is sticky
        ack_wait = 4; rdata_v = 32'h1111_2222;
        bus_req(32'h0000_1040, 32'h0, 1'b1, 1'b1, t);
        bus_req(32'h0000_1041, 32'h9999_9999, 1'b0, 1'b0, t2);
        at_cyc(t + 7);
        chk("ovr_busy", {63'h0, busy}, 64'h0);
        chk("ovr_set", {63'h0, overrun}, 64'h1);
        ack_wait = 0;
        bus_req(32'h0000_1050, 32'h7777_0000, 1'b0, 1'b1, t);
        wait_idle("ovr_next");
        chk("ovr_sticky", {63'h0, overrun}, 64'h1);
        pulse_reset();

        // Hit during the ack cycle of ACCESS is dropped and flagged
        ack_wait = 1;
        bus_req(32'h0000_1060, 32'h0000_0060, 1'b0, 1'b1, t);
        bus_req(32'h0000_1061, 32'h0000_0061, 1'b0, 1'b0, t2);
        at_cyc(t + 4);
        chk("ackcyc_overrun", {63'h0, overrun}, 64'h1);
        chk("ackcyc_busy", {63'h0, busy}, 64'h0);
        pulse_reset();

        // Reset mid-ACCESS abandons the request
        ack_wait = -1;
        bus_req(32'h0000_1080, 32'h0, 1'b1, 1'b0, t);
        @(posedge clk); #2;
        chk("midrst_req_before", {63'h0, dev_if.dev_req}, 64'h1);
        rst = 1'b1;
        #1;
        chk("midrst_req_async", {63'h0, dev_if.dev_req}, 64'h0);
        chk("midrst_busy", {63'h0, busy}, 64'h0);
        chk("midrst_bus_z", {63'h0, bus_control[0] === 1'b1}, 64'h0);
        @(posedge clk); #2; rst = 1'b0;
        ack_wait = 0; rdata_v = 32'h5555_AAAA;
        bus_req(32'h0000_10AA, 32'h0, 1'b1, 1'b1, t);
        wait_idle("post_rst");

`ifdef BIU_SLAVE_TIMEOUT_EN
        // Read never acked: error data after four request cycles
        ack_wait = -1;
        bus_req(32'h0000_10C0, 32'h0, 1'b1, 1'b0, t);
        b.data = 32'hDEAD_BEEF; b.cyc = t + 5;
        bus_q.push_back(b);
        at_cyc(t + 4);
        chk("to_req_last", {63'h0, dev_if.dev_req}, 64'h1);
        chk("to_pulse_pre", {63'h0, timeout}, 64'h0);
        at_cyc(t + 5);
        chk("to_pulse", {63'h0, timeout}, 64'h1);
        chk("to_req_drop", {63'h0, dev_if.dev_req}, 64'h0);
        at_cyc(t + 6);
        chk("to_pulse_post", {63'h0, timeout}, 64'h0);
        chk("to_idle", {63'h0, busy}, 64'h0);
        ack_wait = 0;
`endif

        repeat (4) @(negedge clk);
        chk("bus_q_drained", 64'(bus_q.size()), 64'h0);
        chk("dev_q_drained", 64'(dev_q.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/biu_slave.md
Name: biu_slave

Overview:
Bus Interface Unit, slave side. Sits on the shared bus opposite the bus master: decodes each bus request against its address window, captures it, and runs a req/ack handshake with a local device (register file, memory, peripheral). For reads it drives the device's data back onto the bus for exactly one cycle with data_valid set. For writes no bus response is given.

Parameters:
ADDR_WIDTH, 32, bus address width
DATA_WIDTH, 32, bus data width
BASE_ADDR, 32'h0000_0000, first address of slave window; must be aligned to 2^SIZE_BITS
SIZE_BITS, 8, window is 2^SIZE_BITS addresses; device offset width
TIMEOUT_CYCLES, 16, device ack timeout; used only with BIU_SLAVE_TIMEOUT_EN; must be >=1
ERR_DATA, 32'hDEAD_BEEF, read data returned on timeout; used only with BIU_SLAVE_TIMEOUT_EN

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
bus_address  input  ADDR_WIDTH  bus address, driven by master
bus_data  inout  DATA_WIDTH  bus data; slave drives only in RESPOND, else 'z
bus_control  inout  2  [1]=rnw, [0]=data_valid; slave drives only in RESPOND, else 'z
dev_req  output  1  request to device, held until dev_ack
dev_rnw  output  1  1=read, 0=write; stable while dev_req
dev_addr  output  SIZE_BITS  offset within window; stable while dev_req
dev_wdata  output  DATA_WIDTH  write data; stable while dev_req
dev_ack  input  1  device completion; sampled only while dev_req=1
dev_rdata  input  DATA_WIDTH  read data, valid in dev_ack cycle
busy  output  1  state != IDLE
overrun  output  1  sticky; set when a hit arrives while not IDLE; cleared only by rst

Behaviour:
- Reset (async, rst=1): state=IDLE; dev_req=0, dev_rnw=0, dev_addr=0, dev_wdata=0, overrun=0, busy=0; bus_data/bus_control='z; internal rdata_q=0.
- Hit = bus_control[0]=1 AND BASE_ADDR <= bus_address < BASE_ADDR+2^SIZE_BITS. Only bus_control[0] qualifies a request; in every other cycle bus inputs are ignored.
- FSM, one-hot, states IDLE, ACCESS, RESPOND.
- IDLE: on hit, register bus_address[SIZE_BITS-1:0], bus_data, bus_control[1]; go to ACCESS. Miss: stay.
- ACCESS: dev_req=1 with registered fields. On dev_ack: read -> rdata_q<=dev_rdata, go to RESPOND; write -> go to IDLE. Otherwise stay. dev_req drops the cycle after the ack cycle; there are no back-to-back device transactions.
- RESPOND: drive bus_data=rdata_q and bus_control=2'b01 for exactly one cycle, then IDLE. In all other states bus_data and bus_control are 'z.
- Latency: a request on the bus in cycle T gives dev_req high in T+1. With a combinational ack in T+1, the read response is on the bus in T+2. Each extra device wait cycle adds 1.
- Write with ack in T+1: back in IDLE at T+2 and able to accept a request in T+2.
- Hit while in ACCESS or RESPOND: request dropped, overrun<=1, state unaffected.
- Hit in same cycle as FSM returns to IDLE (i.e. while in RESPOND or ack cycle of ACCESS): dropped and flagged; acceptance only occurs when in IDLE.
- Reset mid-ACCESS: dev_req drops asynchronously; the device must tolerate an abandoned request.

Optional Feature:
- Macro BIU_SLAVE_TIMEOUT_EN.
- Defined: a counter clears on entry to ACCESS and increments each ACCESS cycle without dev_ack. When it reaches TIMEOUT_CYCLES without an ack, dev_req drops.
  - Read: rdata_q<=ERR_DATA, go to RESPOND.
  - Write: go to IDLE (write abandoned).
  - Either case: adds output port timeout (1 bit), pulsed for one cycle on expiry, reset 0.
  - Ack and expiry in the same cycle: ack wins.
- Undefined: no counter, no timeout port; ACCESS waits indefinitely.

Test Plan:
- Read, BASE_ADDR=0x1000, bus req addr 0x1004 rnw=1, dev_ack same cycle as dev_req with rdata 0xCAFEF00D -> dev_addr=0x04; bus_data=0xCAFEF00D, bus_control=01 exactly at T+2, 'z at T+3.
- Write addr 0x10FF data 0x12345678, dev_ack after 3 wait cycles -> dev_req high 4 cycles, dev_wdata stable 0x12345678, bus never driven, busy falls after ack.
- Miss: request at 0x2000 and at 0x0FFF -> no dev_req, state IDLE, overrun=0.
- Overrun: read held 5 cycles by no ack, second hit during ACCESS -> overrun=1 sticky, only first transaction completes; rst clears overrun.
- Reset mid-ACCESS: assert rst with dev_req=1 -> dev_req=0 immediately, bus 'z, next hit after reset serviced normally.
- With BIU_SLAVE_TIMEOUT_EN, TIMEOUT_CYCLES=4, read never acked -> timeout pulse one cycle, bus_data=0xDEADBEEF with control=01 for one cycle, then IDLE.
